// File: rtl/updown_seq_ctrl_if.sv
// Bus interface for updown_seq_ctrl: run control, bounds and status.
// The master drives the run request and bounds; the slave (the counter
// controller) drives the count and status back.
interface updown_seq_ctrl_if #(
    parameter int BITS  = 4,
    parameter int TBITS = 4
);
    logic             start;
    logic             abort;
    logic             hold;
    logic [1:0]       mode;
    logic [BITS-1:0]  limit_lo;
    logic [BITS-1:0]  limit_hi;
    logic [TBITS-1:0] trips;
    logic [BITS-1:0]  Q;
    logic             dir;
    logic             busy;
    logic             done;
    logic             err;
    logic [TBITS-1:0] trip_cnt;

    modport master (
        output start, abort, hold, mode, limit_lo, limit_hi, trips,
        input  Q, dir, busy, done, err, trip_cnt
    );

    modport slave (
        input  start, abort, hold, mode, limit_lo, limit_hi, trips,
        output Q, dir, busy, done, err, trip_cnt
    );
endinterface

// File: rtl/updown_seq_ctrl.sv
// Up/down sequence controller: counts between registered bounds in
// one-shot up, one-shot down or ping-pong mode, with hold, abort and a
// round-trip counter. Bounds, mode and trip count are captured at start
// so input changes during a run have no effect.
module updown_seq_ctrl #(
    parameter int BITS  = 4,
    parameter int TBITS = 4
) (
    input  logic             clk,
    input  logic             reset,
    updown_seq_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN_UP,
        S_RUN_DOWN,
        S_DONE
    } state_t;

    state_t           state_r, state_n;
    logic [BITS-1:0]  q_r, q_n;
    logic [TBITS-1:0] trip_r, trip_n;
    logic             err_r, err_n;
    logic [1:0]       mode_r, mode_n;
    logic [BITS-1:0]  lo_r, lo_n;
    logic [BITS-1:0]  hi_r, hi_n;
    logic [TBITS-1:0] trips_r, trips_n;
    logic [TBITS-1:0] trip_target;

    // trips=0 is treated as a single round trip.
    assign trip_target = (trips_r == '0) ? TBITS'(1) : trips_r;

    // State and datapath registers; asynchronous reset clears everything.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= S_IDLE;
            q_r     <= '0;
            trip_r  <= '0;
            err_r   <= 1'b0;
            mode_r  <= 2'b00;
            lo_r    <= '0;
            hi_r    <= '0;
            trips_r <= '0;
        end else begin
            state_r <= state_n;
            q_r     <= q_n;
            trip_r  <= trip_n;
            err_r   <= err_n;
            mode_r  <= mode_n;
            lo_r    <= lo_n;
            hi_r    <= hi_n;
            trips_r <= trips_n;
        end
    end

    // Next-state and next-datapath decode for the run FSM.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_n = state_r;
        q_n     = q_r;
        trip_n  = trip_r;
        err_n   = 1'b0;
        mode_n  = mode_r;
        lo_n    = lo_r;
        hi_n    = hi_r;
        trips_n = trips_r;

        case (state_r)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.limit_lo < bus.limit_hi) begin
                        mode_n  = bus.mode;
                        lo_n    = bus.limit_lo;
                        hi_n    = bus.limit_hi;
                        trips_n = bus.trips;
                        trip_n  = '0;
                        if (bus.mode == 2'b01) begin
                            q_n     = bus.limit_hi;
                            state_n = S_RUN_DOWN;
                        end else begin
                            q_n     = bus.limit_lo;
                            state_n = S_RUN_UP;
                        end
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end

            S_RUN_UP: begin
                if (bus.abort) begin
                    state_n = S_IDLE;
                end else if (!bus.hold) begin
                    if (q_r < hi_r) begin
                        q_n = q_r + 1'b1;
                    end else if (mode_r[1]) begin
                        // Ping-pong turns around without dwelling on hi.
                        q_n     = hi_r - 1'b1;
                        state_n = S_RUN_DOWN;
                    end else begin
                        state_n = S_DONE;
                    end
                end
            end

            S_RUN_DOWN: begin
                if (bus.abort) begin
                    state_n = S_IDLE;
                end else if (!bus.hold) begin
                    if (q_r > lo_r) begin
                        q_n = q_r - 1'b1;
                    end else if (mode_r[1]) begin
                        // Reaching lo completes one round trip.
                        trip_n = trip_r + 1'b1;
                        if (trip_n == trip_target) begin
                            state_n = S_DONE;
                        end else begin
                            q_n     = lo_r + 1'b1;
                            state_n = S_RUN_UP;
                        end
                    end else begin
                        state_n = S_DONE;
                    end
                end
            end

            S_DONE: begin
                state_n = S_IDLE;
            end

            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // Outputs are registers or direct state decodes.
    assign bus.Q        = q_r;
    assign bus.trip_cnt = trip_r;
    assign bus.err      = err_r;
    assign bus.dir      = (state_r == S_RUN_UP);
    assign bus.busy     = (state_r == S_RUN_UP) || (state_r == S_RUN_DOWN);
    assign bus.done     = (state_r == S_DONE);

endmodule
